// File: rtl/stall_halt_controller.sv
// Pipeline stall/halt sequencer: inserts fence/ecall bubbles, drains before ebreak halt.
// Optional macro HALT_RESUME_EN adds a resume port that leaves the halted state.
module stall_halt_controller #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] stall_stop,
    input  logic       id_valid,
`ifdef HALT_RESUME_EN
    input  logic       resume,
`endif
    output logic       pc_write,
    output logic       ifid_write,
    output logic       nop_inject,
    output logic       halted,
    output logic [7:0] stall_events
);

    localparam int unsigned CW = 4;
    localparam int unsigned EW = 8;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_STALL  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [1:0] CODE_STALL = 2'b01;
    localparam logic [1:0] CODE_HALT  = 2'b10;

    localparam logic [CW-1:0] STALL_LOAD = CW'(STALL_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
    localparam logic [EW-1:0] EV_MAX     = {EW{1'b1}};

    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [EW-1:0] events_d;
    logic          run_d;
    logic          halted_d;

    // Next-state, counter and event-count logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        events_d = stall_events;
        case (state)
            S_RUN: begin
                if (id_valid && stall_stop == CODE_STALL) begin
                    state_d = S_STALL;
                    cnt_d   = STALL_LOAD;
                    if (stall_events != EV_MAX) begin
                        events_d = stall_events + EW'(1);
                    end
                end else if (id_valid && stall_stop == CODE_HALT) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            S_STALL: begin
                if (cnt == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt == '0) begin
                    state_d = S_HALTED;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_HALTED: begin
`ifdef HALT_RESUME_EN
                if (resume) begin
                    state_d = S_RUN;
                end
`endif
            end
            default: state_d = S_RUN;
        endcase
    end

    // Outputs are registered from the next state so they always match the state register
    always_comb begin
        run_d    = (state_d == S_RUN);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RUN;
            cnt          <= '0;
            stall_events <= '0;
            pc_write     <= 1'b1;
            ifid_write   <= 1'b1;
            nop_inject   <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            stall_events <= events_d;
            pc_write     <= run_d;
            ifid_write   <= run_d;
            nop_inject   <= !run_d;
            halted       <= halted_d;
        end
    end

endmodule

// File: tb/tb_stall_halt_controller.sv
// Bench for stall_halt_controller: two instances (default and STALL_CYCLES=4) checked
// every cycle against a bubble-count model, plus hand-computed literal checks.
module tb_stall_halt_controller;

    localparam int N = 2;
    localparam int SC0 = 1;
    localparam int SC1 = 4;
    localparam int DC = 3;

    logic       clk;
    logic       rst_n;
    logic [1:0] ss[N];
    logic       vld[N];
    logic       res[N];
    logic       pcw[N];
    logic       ifw[N];
    logic       nop[N];
    logic       hlt[N];
    logic [7:0] ev[N];

    int checks;
    int failures;

    // Model: remaining bubble cycles, halt-after-bubbles flag, halted flag, accepted stalls
    int m_bub[N];
    int m_hp[N];
    int m_hlt[N];
    int m_ev[N];

    stall_halt_controller #(.STALL_CYCLES(SC0), .DRAIN_CYCLES(DC)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall_stop(ss[0]), .id_valid(vld[0]),
`ifdef HALT_RESUME_EN
        .resume(res[0]),
`endif
        .pc_write(pcw[0]), .ifid_write(ifw[0]), .nop_inject(nop[0]),
        .halted(hlt[0]), .stall_events(ev[0])
    );

    stall_halt_controller #(.STALL_CYCLES(SC1), .DRAIN_CYCLES(DC)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall_stop(ss[1]), .id_valid(vld[1]),
`ifdef HALT_RESUME_EN
        .resume(res[1]),
`endif
        .pc_write(pcw[1]), .ifid_write(ifw[1]), .nop_inject(nop[1]),
        .halted(hlt[1]), .stall_events(ev[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < N; i++) begin
            int b, hp, h, e, sc;
            b  = m_bub[i];
            hp = m_hp[i];
            h  = m_hlt[i];
            e  = m_ev[i];
            sc = (i == 0) ? SC0 : SC1;
            if (!rst_n) begin
                b = 0; hp = 0; h = 0; e = 0;
            end else if (b == 0 && h == 0) begin
                if (vld[i] && ss[i] == 2'b01) begin
                    b = sc;
                    if (e < 255) e = e + 1;
                end else if (vld[i] && ss[i] == 2'b10) begin
                    b = DC;
                    hp = 1;
                end
            end else if (b > 0) begin
                b = b - 1;
                if (b == 0 && hp == 1) begin
                    h = 1;
                    hp = 0;
                end
            end
`ifdef HALT_RESUME_EN
            else if (h == 1 && res[i]) begin
                h = 0;
            end
`endif
            m_bub[i] <= b;
            m_hp[i]  <= hp;
            m_hlt[i] <= h;
            m_ev[i]  <= e;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            int run;
            run = (m_bub[i] == 0 && m_hlt[i] == 0) ? 1 : 0;
            chk($sformatf("u%0d.pc_write", i), int'(pcw[i]), run);
            chk($sformatf("u%0d.ifid_write", i), int'(ifw[i]), run);
            chk($sformatf("u%0d.nop_inject", i), int'(nop[i]), 1 - run);
            chk($sformatf("u%0d.halted", i), int'(hlt[i]), m_hlt[i]);
            chk($sformatf("u%0d.stall_events", i), int'(ev[i]), m_ev[i]);
        end
    end

    task automatic cyc(input int i, input logic [1:0] s, input logic v, input int n);
        ss[i]  = s;
        vld[i] = v;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
        ss[i]  = 2'b00;
        vld[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] pat;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < N; i++) begin
            ss[i] = 2'b00; vld[i] = 1'b0; res[i] = 1'b0;
            m_bub[i] = 0; m_hp[i] = 0; m_hlt[i] = 0; m_ev[i] = 0;
        end
        rst_n = 1'b1;
        #1;
        do_reset();
        chk("reset.pc_write", int'(pcw[0]), 1);
        chk("reset.nop_inject", int'(nop[0]), 0);
        chk("reset.halted", int'(hlt[0]), 0);
        chk("reset.stall_events", int'(ev[0]), 0);

        // Reserved code and unqualified requests leave RUN alone
        cyc(0, 2'b11, 1'b1, 10);
        cyc(0, 2'b01, 1'b0, 10);
        chk("ignore.pc_write", int'(pcw[0]), 1);
        chk("ignore.stall_events", int'(ev[0]), 0);

        // Single stall with one bubble
        cyc(0, 2'b01, 1'b1, 1);
        chk("stall1.bubble_nop", int'(nop[0]), 1);
        chk("stall1.bubble_pcw", int'(pcw[0]), 0);
        cyc(0, 2'b00, 1'b0, 1);
        chk("stall1.back_run", int'(pcw[0]), 1);
        chk("stall1.events", int'(ev[0]), 1);

        // Held request on the 4-bubble instance: 4 bubbles, RUN, then re-accept
        ss[1] = 2'b01;
        vld[1] = 1'b1;
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            pat = {pat[4:0], nop[1]};
        end
        ss[1] = 2'b00;
        vld[1] = 1'b0;
        chk("stall4.pattern", int'(pat), int'(6'b111101));
        chk("stall4.events", int'(ev[1]), 2);
        cyc(1, 2'b00, 1'b0, 5);
        chk("stall4.back_run", int'(pcw[1]), 1);

        // Halt: three drain cycles, then halted
        cyc(0, 2'b10, 1'b1, 1);
        chk("drain.c1", int'(hlt[0]) * 2 + int'(nop[0]), 1);
        cyc(0, 2'b00, 1'b0, 2);
        chk("drain.c3", int'(hlt[0]) * 2 + int'(nop[0]), 1);
        cyc(0, 2'b00, 1'b0, 1);
        chk("halt.entered", int'(hlt[0]), 1);
        cyc(0, 2'b01, 1'b1, 5);
        cyc(0, 2'b10, 1'b1, 5);
        chk("halt.sticky", int'(hlt[0]), 1);
        chk("halt.events", int'(ev[0]), 1);

`ifdef HALT_RESUME_EN
        do_reset();
        res[0] = 1'b1;
        cyc(0, 2'b10, 1'b1, 1);
        cyc(0, 2'b00, 1'b0, 2);
        chk("resume.ignored_in_drain", int'(hlt[0]) * 2 + int'(nop[0]), 1);
        res[0] = 1'b0;
        cyc(0, 2'b00, 1'b0, 2);
        chk("resume.halted", int'(hlt[0]), 1);
        res[0] = 1'b1;
        cyc(0, 2'b00, 1'b0, 1);
        res[0] = 1'b0;
        chk("resume.run", int'(pcw[0]) * 2 + int'(hlt[0]), 2);
`endif

        // Asynchronous reset in the middle of a drain
        do_reset();
        cyc(0, 2'b10, 1'b1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset.pc_write", int'(pcw[0]), 1);
        chk("areset.halted", int'(hlt[0]), 0);
        chk("areset.nop_inject", int'(nop[0]), 0);
        chk("areset.stall_events", int'(ev[0]), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(0, 2'b00, 1'b0, 4);
        chk("areset.no_bubble", int'(pcw[0]), 1);

        // 300 accepted stalls saturate the counter
        cyc(0, 2'b01, 1'b1, 600);
        cyc(0, 2'b00, 1'b0, 2);
        chk("saturate.events", int'(ev[0]), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
